// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD host: command codes, host FSM states and
// the bit positions of the sticky error flags.
package lcd_pkg;

    localparam int CMD_W = 4;

    // Command codes. Only WRITE has a meaning to the host; every other code
    // is forwarded to the controller unchanged.
    localparam logic [CMD_W-1:0] CMD_WRITE = 4'd0;
    localparam logic [CMD_W-1:0] CMD_INIT  = 4'd1;
    localparam logic [CMD_W-1:0] CMD_CLEAR = 4'd2;

    // Host sequencer states.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_IDLE = 3'd3,
        S_CAPTURE   = 3'd4,
        S_DONE      = 3'd5
    } host_state_e;

    // Bit positions inside the sticky err vector.
    localparam int ERR_OVF     = 0;
    localparam int ERR_STRAY   = 1;
    localparam int ERR_TIMEOUT = 2;

endpackage

// File: rtl/lcd_cmd_host_if.sv
// Host <-> LCD controller link: command strobe, busy pacing and the
// controller's IRAM write burst.
//
// Handshake: cmd is qualified by cmd_valid, a single-cycle strobe that the
// host only raises when busy is low; the controller acknowledges by raising
// busy and holds it until it can accept the next command. IRAM_A/IRAM_D are
// qualified by IRAM_valid alone (no back-pressure; the host must always
// accept a write). ctrl_done is a level the controller raises at burst end.
interface lcd_cmd_host_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) ();
    logic [3:0]        cmd;
    logic              cmd_valid;
    logic              busy;
    logic              IRAM_valid;
    logic [ADDR_W-1:0] IRAM_A;
    logic [DATA_W-1:0] IRAM_D;
    logic              ctrl_done;

    modport master (
        output cmd, cmd_valid,
        input  busy, IRAM_valid, IRAM_A, IRAM_D, ctrl_done
    );

    modport slave (
        input  cmd, cmd_valid,
        output busy, IRAM_valid, IRAM_A, IRAM_D, ctrl_done
    );
endinterface

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO. dout shows the head entry whenever empty is low.
// A push while full is dropped and reported on overflow, unless a pop in
// the same cycle frees the slot, in which case both are honoured.
module lcd_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign empty    = (count == '0);
    assign dout     = mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    // Pointers, count and the registered full flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/lcd_cmd_host.sv
// LCD command host: queues a command script, issues it one command at a
// time paced by busy, and after a WRITE command captures the controller's
// IRAM burst into a local image with a running checksum and readback port.
module lcd_cmd_host
    import lcd_pkg::*;
#(
    parameter int CQ_DEPTH     = 16,
    parameter int IMG_WORDS    = 64,
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cq_push,
    input  logic [3:0]        cq_cmd,
    output logic              cq_full,
    lcd_cmd_host_if.master    ctrl,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [6:0]        wr_count,
    output logic [15:0]       checksum,
    output logic              cap_done,
    output logic [2:0]        err,
    output host_state_e       state
);
    localparam int         TW      = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [6:0] IMG_CNT = 7'(IMG_WORDS);

    logic [3:0]           fifo_dout;
    logic                 fifo_empty;
    logic                 fifo_ovf;
    logic                 fifo_pop;
    logic [TW-1:0]        timer;
    logic [DATA_W-1:0]    img [IMG_WORDS];
    logic [IMG_WORDS-1:0] valid_map;
    logic                 cap_we;
    logic                 first_write;
    logic [6:0]           wr_count_next;

    lcd_cmd_fifo #(
        .DEPTH (CQ_DEPTH),
        .W     (4)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (cq_push),
        .din      (cq_cmd),
        .pop      (fifo_pop),
        .dout     (fifo_dout),
        .full     (cq_full),
        .empty    (fifo_empty),
        .overflow (fifo_ovf)
    );

    // Only IDLE pulls from the queue, so at most one command is ever in flight.
    assign fifo_pop    = (state == S_IDLE) && !fifo_empty && !ctrl.busy;
    assign cap_we      = (state == S_CAPTURE) && ctrl.IRAM_valid;
    assign first_write = !valid_map[ctrl.IRAM_A];

    // Distinct-address count after this cycle's capture, saturating at a full image.
    always_comb begin
        wr_count_next = wr_count;
        if (cap_we && first_write && (wr_count != IMG_CNT)) begin
            wr_count_next = wr_count + 1'b1;
        end
    end

    // Host sequencer with registered command, strobe, counters and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            ctrl.cmd       <= '0;
            ctrl.cmd_valid <= 1'b0;
            timer          <= '0;
            wr_count       <= '0;
            checksum       <= '0;
            cap_done       <= 1'b0;
            err            <= '0;
        end else begin
            ctrl.cmd_valid <= 1'b0;
            if (fifo_ovf) err[ERR_OVF] <= 1'b1;
            if (ctrl.IRAM_valid && (state != S_CAPTURE)) err[ERR_STRAY] <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (fifo_pop) begin
                        ctrl.cmd       <= fifo_dout;
                        ctrl.cmd_valid <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (ctrl.busy) begin
                        state <= (ctrl.cmd == CMD_WRITE) ? S_CAPTURE : S_WAIT_IDLE;
                    end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
                        // Unacknowledged command is dropped, not retried.
                        err[ERR_TIMEOUT] <= 1'b1;
                        state            <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (!ctrl.busy) state <= S_IDLE;
                end
                S_CAPTURE: begin
                    if (cap_we) checksum <= checksum + 16'(ctrl.IRAM_D);
                    wr_count <= wr_count_next;
                    if (ctrl.ctrl_done || (wr_count_next == IMG_CNT)) begin
                        cap_done <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    cap_done <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Image storage; unwritten words are masked by the valid map, so no reset.
    always_ff @(posedge clk) begin
        if (cap_we) img[ctrl.IRAM_A] <= ctrl.IRAM_D;
    end

    // Valid map marks every address written during capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_map <= '0;
        end else if (cap_we) begin
            valid_map[ctrl.IRAM_A] <= 1'b1;
        end
    end

    // Registered readback, returning zero for never-written locations.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= valid_map[rd_addr] ? img[rd_addr] : '0;
        end
    end
endmodule

// File: tb/tb_lcd_cmd_host.sv
// Directed bench for lcd_cmd_host with a busy-pacing controller model and a
// queue of expected command strobes.
module tb_lcd_cmd_host;
    import lcd_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cq_push = 1'b0;
    logic [3:0]  cq_cmd = '0;
    logic        cq_full;
    logic [5:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic [6:0]  wr_count;
    logic [15:0] checksum;
    logic        cap_done;
    logic [2:0]  err;
    host_state_e state_dbg;

    logic        model_busy = 1'b0;
    logic        hold_busy = 1'b0;
    int          busy_cnt = 0;
    int          strobes_seen = 0;
    int          ignore_at = -1;
    logic        prev_valid = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] exp_q[$];

    lcd_cmd_host_if #(.ADDR_W(6), .DATA_W(8)) ctrl ();

    assign ctrl.busy = model_busy | hold_busy;

    lcd_cmd_host dut (
        .clk      (clk),
        .reset    (reset),
        .cq_push  (cq_push),
        .cq_cmd   (cq_cmd),
        .cq_full  (cq_full),
        .ctrl     (ctrl),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_count (wr_count),
        .checksum (checksum),
        .cap_done (cap_done),
        .err      (err),
        .state    (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Controller model: busy rises the negedge after a strobe and stays high
    // for three cycles; the strobe numbered ignore_at gets no response.
    always @(negedge clk) begin
        if (reset) begin
            model_busy = 1'b0;
            busy_cnt   = 0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) model_busy = 1'b0;
        end else if (ctrl.cmd_valid) begin
            if (strobes_seen != ignore_at) begin
                model_busy = 1'b1;
                busy_cnt   = 3;
            end
            strobes_seen++;
        end
    end

    // Strobe monitor: every strobe is one cycle, never under busy, and
    // carries the next expected code.
    always @(posedge clk) begin
        #1;
        if (ctrl.cmd_valid) begin
            check("strobe_width", prev_valid, 1'b0);
            check("strobe_busy", ctrl.busy, 1'b0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", ctrl.cmd, 32'hdead);
            end else begin
                check("cmd_code", ctrl.cmd, exp_q.pop_front());
            end
        end
        prev_valid = ctrl.cmd_valid;
    end

    task automatic push_cmd(input logic [3:0] c, input bit expect_issue);
        cq_push = 1'b1;
        cq_cmd  = c;
        if (expect_issue) exp_q.push_back(c);
        @(negedge clk);
        cq_push = 1'b0;
    endtask

    task automatic iram_write(input logic [5:0] a, input logic [7:0] d);
        ctrl.IRAM_valid = 1'b1;
        ctrl.IRAM_A     = a;
        ctrl.IRAM_D     = d;
        @(negedge clk);
        ctrl.IRAM_valid = 1'b0;
    endtask

    task automatic wait_state(input host_state_e s, input int limit);
        int n = 0;
        while (state_dbg !== s && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_state", state_dbg, s);
    endtask

    task automatic wait_drained(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic read_check(input string tag, input logic [5:0] a, input logic [7:0] exp);
        rd_addr = a;
        @(negedge clk);
        check(tag, rd_data, exp);
    endtask

    task automatic check_reset_values();
        check("rst_cmd", ctrl.cmd, 4'd0);
        check("rst_cmd_valid", ctrl.cmd_valid, 1'b0);
        check("rst_cq_full", cq_full, 1'b0);
        check("rst_rd_data", rd_data, 8'd0);
        check("rst_wr_count", wr_count, 7'd0);
        check("rst_checksum", checksum, 16'd0);
        check("rst_cap_done", cap_done, 1'b0);
        check("rst_err", err, 3'b000);
        check("rst_state", state_dbg, S_IDLE);
    endtask

    initial begin
        ctrl.IRAM_valid = 1'b0;
        ctrl.IRAM_A     = '0;
        ctrl.IRAM_D     = '0;
        ctrl.ctrl_done  = 1'b0;

        // Power-on reset.
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        @(negedge clk);

        // Stray IRAM write while idle.
        iram_write(6'd9, 8'h55);
        @(negedge clk);
        check("stray_err", err, 3'b010);
        check("stray_wr_count", wr_count, 7'd0);

        // Controller ignores the first strobe: timeout, then next command issues.
        ignore_at = 0;
        push_cmd(4'd3, 1'b1);
        push_cmd(4'd4, 1'b1);
        repeat (5) @(negedge clk);
        check("timeout_not_yet", err[2], 1'b0);
        repeat (35) @(negedge clk);
        check("timeout_err", err, 3'b110);
        check("timeout_next_issued", exp_q.size(), 0);
        check("timeout_idle", state_dbg, S_IDLE);
        ignore_at = -1;

        // Script 1,2,0 then a full 64-word burst with data = address.
        push_cmd(4'd1, 1'b1);
        push_cmd(4'd2, 1'b1);
        push_cmd(4'd0, 1'b1);
        wait_state(S_CAPTURE, 100);
        check("script_issued", exp_q.size(), 0);
        for (int a = 0; a < 64; a++) begin
            ctrl.IRAM_valid = 1'b1;
            ctrl.IRAM_A     = 6'(a);
            ctrl.IRAM_D     = 8'(a);
            @(negedge clk);
        end
        ctrl.IRAM_valid = 1'b0;
        check("burst_wr_count", wr_count, 7'd64);
        check("burst_checksum", checksum, 16'd2016);
        check("burst_cap_done", cap_done, 1'b1);
        check("burst_state", state_dbg, S_DONE);
        check("burst_err", err, 3'b110);
        read_check("readback_37", 6'd37, 8'd37);
        read_check("readback_0", 6'd0, 8'd0);
        read_check("readback_63", 6'd63, 8'd63);

        // DONE is terminal: a pushed command is never issued.
        push_cmd(4'd5, 1'b0);
        repeat (20) @(negedge clk);
        check("done_terminal", state_dbg, S_DONE);

        // Fresh run: duplicate writes, then reset in the middle of capture.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        push_cmd(4'd0, 1'b1);
        wait_state(S_CAPTURE, 50);
        iram_write(6'd5, 8'd10);
        iram_write(6'd5, 8'd20);
        iram_write(6'd6, 8'd7);
        check("dup_wr_count", wr_count, 7'd2);
        check("dup_checksum", checksum, 16'd37);
        read_check("dup_readback_5", 6'd5, 8'd20);
        read_check("unwritten_7", 6'd7, 8'd0);
        for (int a = 10; a < 28; a++) iram_write(6'(a), 8'd1);
        check("mid_wr_count", wr_count, 7'd20);
        check("mid_checksum", checksum, 16'd55);
        check("mid_state", state_dbg, S_CAPTURE);
        reset = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 64; a++) read_check("cleared_map", 6'(a), 8'd0);

        // Overflow: queue blocked by busy, 17 pushes, only 16 issued later.
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) push_cmd(4'((i % 15) + 1), 1'b1);
        check("ovf_full", cq_full, 1'b1);
        check("ovf_err_clear", err, 3'b000);
        push_cmd(4'd9, 1'b0);
        check("ovf_err", err, 3'b001);
        check("ovf_still_full", cq_full, 1'b1);
        check("ovf_blocked", state_dbg, S_IDLE);
        hold_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ovf_not_full_after_pop", cq_full, 1'b0);
        wait_drained(400);
        repeat (30) @(negedge clk);
        check("ovf_final_idle", state_dbg, S_IDLE);
        check("ovf_final_err", err, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
